// File: rtl/mc_control.sv
// Multi-cycle control unit for a MIPS-style subset: sequences FETCH/DECODE/EXEC/MEM/WB,
// decodes the latched instruction into datapath controls, and bounds memory waits.
module mc_control #(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 0,
    parameter int CNT_W   = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WORD_W-1:0] instr,
    input  logic              ihit,
    input  logic              dhit,
    output logic              iREN,
    output logic              dREN,
    output logic              dWEN,
    output logic              ir_load,
    output logic              pc_en,
    output logic              regwrite,
    output logic              alusrc,
    output logic              extop,
    output logic [1:0]        regdst,
    output logic [1:0]        memtoreg,
    output logic [3:0]        aluop,
    output logic [1:0]        branch,
    output logic [1:0]        jump_sel,
    output logic              halt,
    output logic              timeout_err,
    output logic [2:0]        state_o
);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B, OP_HALT = 6'h3F;

    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR  = 6'h08, FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Encodings match aluop_t in the CPU types package.
    localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3;
    localparam logic [3:0] ALU_AND = 4'd4, ALU_OR  = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7;
    localparam logic [3:0] ALU_SLT = 4'd8, ALU_SLTU = 4'd9;

    localparam bit             TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALTED = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    state_t           state_q;
    logic [5:0]       op_q;
    logic [5:0]       funct_q;
    logic [CNT_W-1:0] cnt_q;

    logic       dec_alusrc, dec_extop;
    logic [1:0] dec_regdst, dec_memtoreg, dec_branch, dec_jump;
    logic [3:0] dec_aluop;
    logic       is_lw, is_sw, is_mem, is_wb, is_halt;
    logic       wait_expired;
    logic       unused_instr;

    // Only opcode and funct steer control; the register fields belong to the datapath.
    assign unused_instr = ^instr[WORD_W-7:6];

    always_comb begin
        dec_regdst   = 2'd0;
        dec_alusrc   = 1'b0;
        dec_extop    = 1'b0;
        dec_memtoreg = 2'd0;
        dec_aluop    = ALU_SLL;
        dec_branch   = 2'd0;
        dec_jump     = 2'd0;
        is_lw        = 1'b0;
        is_sw        = 1'b0;
        is_wb        = 1'b0;
        is_halt      = 1'b0;
        case (op_q)
            OP_RTYPE: begin
                dec_regdst = 2'd1;
                is_wb      = 1'b1;
                case (funct_q)
                    FN_SLL:          dec_aluop = ALU_SLL;
                    FN_SRL:          dec_aluop = ALU_SRL;
                    FN_ADD, FN_ADDU: dec_aluop = ALU_ADD;
                    FN_SUB, FN_SUBU: dec_aluop = ALU_SUB;
                    FN_AND:          dec_aluop = ALU_AND;
                    FN_OR:           dec_aluop = ALU_OR;
                    FN_XOR:          dec_aluop = ALU_XOR;
                    FN_NOR:          dec_aluop = ALU_NOR;
                    FN_SLT:          dec_aluop = ALU_SLT;
                    FN_SLTU:         dec_aluop = ALU_SLTU;
                    FN_JR: begin
                        dec_jump = 2'd2;
                        is_wb    = 1'b0;
                    end
                    default: begin
                        dec_regdst = 2'd0;
                        is_wb      = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                dec_alusrc = 1'b1; dec_extop = 1'b1; dec_aluop = ALU_ADD; is_wb = 1'b1;
            end
            OP_SLTI: begin
                dec_alusrc = 1'b1; dec_extop = 1'b1; dec_aluop = ALU_SLT; is_wb = 1'b1;
            end
            OP_SLTIU: begin
                dec_alusrc = 1'b1; dec_extop = 1'b1; dec_aluop = ALU_SLTU; is_wb = 1'b1;
            end
            OP_ANDI: begin
                dec_alusrc = 1'b1; dec_aluop = ALU_AND; is_wb = 1'b1;
            end
            OP_ORI: begin
                dec_alusrc = 1'b1; dec_aluop = ALU_OR; is_wb = 1'b1;
            end
            OP_XORI: begin
                dec_alusrc = 1'b1; dec_aluop = ALU_XOR; is_wb = 1'b1;
            end
            OP_LUI: begin
                dec_alusrc = 1'b1; dec_memtoreg = 2'd3; is_wb = 1'b1;
            end
            OP_LW: begin
                dec_alusrc = 1'b1; dec_extop = 1'b1; dec_aluop = ALU_ADD;
                dec_memtoreg = 2'd1; is_lw = 1'b1;
            end
            OP_SW: begin
                dec_alusrc = 1'b1; dec_extop = 1'b1; dec_aluop = ALU_ADD; is_sw = 1'b1;
            end
            OP_BEQ: begin
                dec_extop = 1'b1; dec_aluop = ALU_SUB; dec_branch = 2'd1;
            end
            OP_BNE: begin
                dec_extop = 1'b1; dec_aluop = ALU_SUB; dec_branch = 2'd2;
            end
            OP_J:   dec_jump = 2'd1;
            OP_JAL: begin
                dec_jump = 2'd1; dec_regdst = 2'd2; dec_memtoreg = 2'd2; is_wb = 1'b1;
            end
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

    assign is_mem       = is_lw | is_sw;
    assign wait_expired = TIMEOUT_EN && (cnt_q == CNT_LIMIT);

    // The wait counter is cleared on every transition into FETCH or MEM.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_RESET;
            op_q    <= '0;
            funct_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_RESET: begin
                    state_q <= S_FETCH;
                    cnt_q   <= '0;
                end
                S_FETCH: begin
                    if (ihit) begin
                        op_q    <= instr[WORD_W-1 -: 6];
                        funct_q <= instr[5:0];
                        state_q <= S_DECODE;
                    end else if (wait_expired) begin
                        state_q <= S_ERROR;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DECODE: state_q <= is_halt ? S_HALTED : S_EXEC;
                S_EXEC: begin
                    if (is_mem) begin
                        state_q <= S_MEM;
                        cnt_q   <= '0;
                    end else if (is_wb) begin
                        state_q <= S_WB;
                    end else begin
                        state_q <= S_FETCH;
                        cnt_q   <= '0;
                    end
                end
                S_MEM: begin
                    if (dhit) begin
                        if (is_sw) begin
                            state_q <= S_FETCH;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= S_WB;
                        end
                    end else if (wait_expired) begin
                        state_q <= S_ERROR;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WB: begin
                    state_q <= S_FETCH;
                    cnt_q   <= '0;
                end
                default: state_q <= state_q;
            endcase
        end
    end

    logic in_reset;
    assign in_reset = (state_q == S_RESET);

    assign iREN        = (state_q == S_FETCH);
    assign ir_load     = (state_q == S_FETCH) && ihit;
    assign dREN        = (state_q == S_MEM) && is_lw;
    assign dWEN        = (state_q == S_MEM) && is_sw;
    assign pc_en       = ((state_q == S_EXEC) && !is_mem && !is_wb)
                       || ((state_q == S_MEM) && is_sw && dhit)
                       || (state_q == S_WB);
    assign regwrite    = (state_q == S_WB);
    assign halt        = (state_q == S_HALTED) || (state_q == S_ERROR);
    assign timeout_err = (state_q == S_ERROR);
    assign state_o     = state_q;

    // A cleared IR would decode as SLL, so the decode outputs are held at zero in RESET.
    assign regdst   = in_reset ? 2'd0 : dec_regdst;
    assign alusrc   = in_reset ? 1'b0 : dec_alusrc;
    assign extop    = in_reset ? 1'b0 : dec_extop;
    assign memtoreg = in_reset ? 2'd0 : dec_memtoreg;
    assign aluop    = in_reset ? 4'd0 : dec_aluop;
    assign branch   = in_reset ? 2'd0 : dec_branch;
    assign jump_sel = in_reset ? 2'd0 : dec_jump;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: one task per scenario, hand-computed expectations.
module tb_mc_control;

    localparam logic [31:0] I_ADDU = 32'h0109_5021;
    localparam logic [31:0] I_LW   = 32'h8D09_0004;
    localparam logic [31:0] I_SW   = 32'hAD09_0008;
    localparam logic [31:0] I_HALT = 32'hFC00_0000;
    localparam logic [31:0] I_BEQ  = 32'h1109_0003;
    localparam logic [31:0] I_JAL  = 32'h0C00_0010;
    localparam logic [31:0] I_BADOP = 32'hF800_0000;
    localparam logic [31:0] I_BADFN = 32'h0109_503F;
    localparam logic [31:0] I_ANDI = 32'h3109_00FF;
    localparam logic [31:0] I_ADDI = 32'h2109_FFFF;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] instr = '0;
    logic        ihit = 1'b0;
    logic        dhit = 1'b0;

    logic       iREN, dREN, dWEN, ir_load, pc_en, regwrite, alusrc, extop, halt, timeout_err;
    logic [1:0] regdst, memtoreg, branch, jump_sel;
    logic [3:0] aluop;
    logic [2:0] state_o;

    logic       nt_iREN, nt_dREN, nt_dWEN, nt_ir_load, nt_pc_en, nt_regwrite, nt_alusrc, nt_extop;
    logic       nt_halt, nt_timeout_err;
    logic [1:0] nt_regdst, nt_memtoreg, nt_branch, nt_jump_sel;
    logic [3:0] nt_aluop;
    logic [2:0] nt_state_o;

    logic [24:0] all_out;
    assign all_out = {iREN, dREN, dWEN, ir_load, pc_en, regwrite, alusrc, extop, regdst,
                      memtoreg, aluop, branch, jump_sel, halt, timeout_err, state_o};

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    mc_control #(.WORD_W(32), .TIMEOUT(4), .CNT_W(8)) u_dut (
        .CLK(CLK), .RST(RST), .instr(instr), .ihit(ihit), .dhit(dhit),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .ir_load(ir_load), .pc_en(pc_en),
        .regwrite(regwrite), .alusrc(alusrc), .extop(extop), .regdst(regdst),
        .memtoreg(memtoreg), .aluop(aluop), .branch(branch), .jump_sel(jump_sel),
        .halt(halt), .timeout_err(timeout_err), .state_o(state_o)
    );

    // Unlimited-wait instance sharing the same stimulus.
    mc_control #(.WORD_W(32), .TIMEOUT(0), .CNT_W(8)) u_dut_nt (
        .CLK(CLK), .RST(RST), .instr(instr), .ihit(ihit), .dhit(dhit),
        .iREN(nt_iREN), .dREN(nt_dREN), .dWEN(nt_dWEN), .ir_load(nt_ir_load), .pc_en(nt_pc_en),
        .regwrite(nt_regwrite), .alusrc(nt_alusrc), .extop(nt_extop), .regdst(nt_regdst),
        .memtoreg(nt_memtoreg), .aluop(nt_aluop), .branch(nt_branch), .jump_sel(nt_jump_sel),
        .halt(nt_halt), .timeout_err(nt_timeout_err), .state_o(nt_state_o)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Leaves both DUTs in RESET with RST released, inputs idle.
    task automatic do_reset;
        ihit = 1'b0; dhit = 1'b0; instr = '0;
        #2 RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    // From RESET: load w through FETCH and stop in DECODE.
    task automatic to_decode(input logic [31:0] w);
        instr = w; ihit = 1'b1;
        tick;
        tick;
        ihit = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        n_cmp++; if (all_out !== 25'd0) begin n_err++; $display("FAIL reset_outputs got %h want 0", all_out); end
        tick;
        n_cmp++; if (state_o !== 3'd1) begin n_err++; $display("FAIL reset_to_fetch state got %0d want 1", state_o); end
        #2 RST = 1'b1;
        #1;
        n_cmp++; if (all_out !== 25'd0) begin n_err++; $display("FAIL reset_async got %h want 0", all_out); end
        $display("tb: reset checks done");
    endtask

    task automatic test_addu;
        do_reset;
        instr = I_ADDU; ihit = 1'b1;
        n_cmp++; if (state_o !== 3'd0) begin n_err++; $display("FAIL addu_s0 got %0d want 0", state_o); end
        tick;
        n_cmp++; if (state_o !== 3'd1) begin n_err++; $display("FAIL addu_s1 got %0d want 1", state_o); end
        n_cmp++; if ({iREN, ir_load, pc_en} !== 3'b110) begin n_err++; $display("FAIL addu_fetch iREN/ir_load/pc_en got %b want 110", {iREN, ir_load, pc_en}); end
        tick; ihit = 1'b0;
        n_cmp++; if (state_o !== 3'd2) begin n_err++; $display("FAIL addu_s2 got %0d want 2", state_o); end
        n_cmp++; if ({regwrite, pc_en} !== 2'b00) begin n_err++; $display("FAIL addu_decode rw/pc got %b want 00", {regwrite, pc_en}); end
        tick;
        n_cmp++; if (state_o !== 3'd3) begin n_err++; $display("FAIL addu_s3 got %0d want 3", state_o); end
        n_cmp++; if ({regwrite, pc_en} !== 2'b00) begin n_err++; $display("FAIL addu_exec rw/pc got %b want 00", {regwrite, pc_en}); end
        tick;
        n_cmp++; if (state_o !== 3'd5) begin n_err++; $display("FAIL addu_s5 got %0d want 5", state_o); end
        n_cmp++; if ({regwrite, pc_en, regdst, aluop} !== {2'b11, 2'd1, 4'd2}) begin n_err++; $display("FAIL addu_wb rw/pc/regdst/aluop got %b want 11_01_0010", {regwrite, pc_en, regdst, aluop}); end
        tick;
        n_cmp++; if ({state_o, regwrite, pc_en} !== {3'd1, 2'b00}) begin n_err++; $display("FAIL addu_back_fetch got %b want 00100", {state_o, regwrite, pc_en}); end
        $display("tb: ADDU instruction sequenced");
    endtask

    task automatic test_lw;
        int cyc = 0;
        do_reset;
        to_decode(I_LW);
        tick;
        n_cmp++; if ({state_o, pc_en} !== {3'd3, 1'b0}) begin n_err++; $display("FAIL lw_exec got %b want 0110", {state_o, pc_en}); end
        tick;
        for (int i = 0; i < 4; i++) begin
            dhit = (i == 3);
            #1;
            if (dREN === 1'b1 && state_o === 3'd4) cyc++;
            n_cmp++; if ({dWEN, pc_en, regwrite} !== 3'b000) begin n_err++; $display("FAIL lw_mem_en cycle %0d got %b want 000", i, {dWEN, pc_en, regwrite}); end
            tick;
        end
        dhit = 1'b0;
        n_cmp++; if (cyc !== 4) begin n_err++; $display("FAIL lw_dren_cycles got %0d want 4", cyc); end
        n_cmp++; if (state_o !== 3'd5) begin n_err++; $display("FAIL lw_wb_state got %0d want 5", state_o); end
        n_cmp++; if ({memtoreg, alusrc, extop, regwrite, pc_en, dREN, regdst} !== {2'd1, 4'b1111, 1'b0, 2'd0}) begin n_err++; $display("FAIL lw_wb_ctrl got %b want 011111000", {memtoreg, alusrc, extop, regwrite, pc_en, dREN, regdst}); end
        $display("tb: LW with 3-cycle data wait");
    endtask

    task automatic test_sw;
        do_reset;
        to_decode(I_SW);
        tick;
        tick;
        n_cmp++; if ({state_o, dWEN, dREN, pc_en} !== {3'd4, 3'b100}) begin n_err++; $display("FAIL sw_mem_wait got %b want 100100", {state_o, dWEN, dREN, pc_en}); end
        tick;
        dhit = 1'b1; #1;
        n_cmp++; if ({dWEN, pc_en, regwrite} !== 3'b110) begin n_err++; $display("FAIL sw_dhit got %b want 110", {dWEN, pc_en, regwrite}); end
        tick; dhit = 1'b0;
        n_cmp++; if ({state_o, regwrite, dWEN} !== {3'd1, 2'b00}) begin n_err++; $display("FAIL sw_after got %b want 00100", {state_o, regwrite, dWEN}); end
        $display("tb: SW with 1-cycle data wait");
    endtask

    task automatic test_timeout;
        do_reset;
        tick;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (state_o !== 3'd1) begin n_err++; $display("FAIL to_fetch_hold cycle %0d got %0d want 1", i, state_o); end
            tick;
        end
        n_cmp++; if ({state_o, timeout_err, halt, iREN} !== {3'd7, 3'b110}) begin n_err++; $display("FAIL to_error got %b want 111110", {state_o, timeout_err, halt, iREN}); end
        n_cmp++; if ({nt_state_o, nt_timeout_err} !== {3'd1, 1'b0}) begin n_err++; $display("FAIL to_unlimited got %b want 0010", {nt_state_o, nt_timeout_err}); end
        ihit = 1'b1; instr = I_ADDU; #1;
        n_cmp++; if ({ir_load, pc_en, dREN, dWEN, regwrite} !== 5'b0) begin n_err++; $display("FAIL to_error_quiet got %b want 00000", {ir_load, pc_en, dREN, dWEN, regwrite}); end
        tick; tick;
        n_cmp++; if ({state_o, timeout_err} !== {3'd7, 1'b1}) begin n_err++; $display("FAIL to_error_sticky got %b want 1111", {state_o, timeout_err}); end
        do_reset;
        tick; tick; tick; tick;
        instr = I_ADDU; ihit = 1'b1; #1;
        n_cmp++; if (ir_load !== 1'b1) begin n_err++; $display("FAIL to_limit_load got %b want 1", ir_load); end
        tick; ihit = 1'b0;
        n_cmp++; if ({state_o, timeout_err} !== {3'd2, 1'b0}) begin n_err++; $display("FAIL to_hit_wins got %b want 0100", {state_o, timeout_err}); end
        $display("tb: fetch timeout and limit-cycle hit");
    endtask

    task automatic test_mem_timeout;
        do_reset;
        to_decode(I_LW);
        tick; tick;
        tick; tick; tick; tick;
        n_cmp++; if ({state_o, timeout_err, dREN} !== {3'd7, 2'b10}) begin n_err++; $display("FAIL to_mem_error got %b want 11110", {state_o, timeout_err, dREN}); end
        $display("tb: data-memory timeout");
    endtask

    task automatic test_halt;
        do_reset;
        to_decode(I_HALT);
        n_cmp++; if (pc_en !== 1'b0) begin n_err++; $display("FAIL halt_decode_pc got %b want 0", pc_en); end
        tick;
        for (int i = 0; i < 10; i++) begin
            ihit = i[0]; #1;
            n_cmp++; if ({state_o, halt, iREN, ir_load, pc_en, regwrite} !== {3'd6, 5'b10000}) begin n_err++; $display("FAIL halt_hold cycle %0d got %b want 11010000", i, {state_o, halt, iREN, ir_load, pc_en, regwrite}); end
            tick;
        end
        ihit = 1'b0;
        RST = 1'b1; #1;
        n_cmp++; if ({halt, state_o} !== 4'd0) begin n_err++; $display("FAIL halt_reset got %b want 0000", {halt, state_o}); end
        $display("tb: HALT held then cleared by reset");
    endtask

    task automatic test_beq_jal;
        do_reset;
        to_decode(I_BEQ);
        n_cmp++; if ({branch, extop, aluop, jump_sel} !== {2'd1, 1'b1, 4'd3, 2'd0}) begin n_err++; $display("FAIL beq_decode got %b want 01_1_0011_00", {branch, extop, aluop, jump_sel}); end
        tick;
        n_cmp++; if ({state_o, pc_en, regwrite} !== {3'd3, 2'b10}) begin n_err++; $display("FAIL beq_exec got %b want 01110", {state_o, pc_en, regwrite}); end
        tick;
        n_cmp++; if ({state_o, pc_en} !== {3'd1, 1'b0}) begin n_err++; $display("FAIL beq_next got %b want 0010", {state_o, pc_en}); end
        instr = I_JAL; ihit = 1'b1;
        tick; ihit = 1'b0;
        n_cmp++; if ({regdst, memtoreg, jump_sel, branch} !== {2'd2, 2'd2, 2'd1, 2'd0}) begin n_err++; $display("FAIL jal_decode got %b want 10100100", {regdst, memtoreg, jump_sel, branch}); end
        tick;
        n_cmp++; if ({state_o, pc_en} !== {3'd3, 1'b0}) begin n_err++; $display("FAIL jal_exec got %b want 0110", {state_o, pc_en}); end
        tick;
        n_cmp++; if ({state_o, regwrite, pc_en} !== {3'd5, 2'b11}) begin n_err++; $display("FAIL jal_wb got %b want 10111", {state_o, regwrite, pc_en}); end
        $display("tb: BEQ then JAL back to back");
    endtask

    task automatic test_nop_extend;
        logic [31:0] bad [2];
        bad[0] = I_BADOP; bad[1] = I_BADFN;
        for (int k = 0; k < 2; k++) begin
            do_reset;
            to_decode(bad[k]);
            tick;
            n_cmp++; if ({state_o, pc_en, regwrite, regdst} !== {3'd3, 2'b10, 2'd0}) begin n_err++; $display("FAIL nop_exec %0d got %b want 0111000", k, {state_o, pc_en, regwrite, regdst}); end
            tick;
            n_cmp++; if ({state_o, dREN, dWEN, regwrite} !== {3'd1, 3'b000}) begin n_err++; $display("FAIL nop_next %0d got %b want 001000", k, {state_o, dREN, dWEN, regwrite}); end
        end
        do_reset;
        to_decode(I_ANDI);
        n_cmp++; if ({extop, alusrc, aluop, regdst} !== {2'b01, 4'd4, 2'd0}) begin n_err++; $display("FAIL andi_decode got %b want 01010000", {extop, alusrc, aluop, regdst}); end
        do_reset;
        to_decode(I_ADDI);
        n_cmp++; if ({extop, alusrc, aluop} !== {2'b11, 4'd2}) begin n_err++; $display("FAIL addi_decode got %b want 110010", {extop, alusrc, aluop}); end
        $display("tb: unknown ops as NOP, extend rule");
    endtask

    task automatic test_reset_mid_mem;
        do_reset;
        to_decode(I_LW);
        tick; tick;
        n_cmp++; if (dREN !== 1'b1) begin n_err++; $display("FAIL midmem_dren got %b want 1", dREN); end
        #2 RST = 1'b1; #1;
        n_cmp++; if (all_out !== 25'd0) begin n_err++; $display("FAIL midmem_async got %h want 0", all_out); end
        @(posedge CLK); #1 RST = 1'b0;
        n_cmp++; if (state_o !== 3'd0) begin n_err++; $display("FAIL midmem_release got %0d want 0", state_o); end
        tick;
        n_cmp++; if (state_o !== 3'd1) begin n_err++; $display("FAIL midmem_fetch got %0d want 1", state_o); end
        $display("tb: reset during MEM");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at 200000, want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_addu;
        test_lw;
        test_sw;
        test_timeout;
        test_mem_timeout;
        test_halt;
        test_beq_jal;
        test_nop_extend;
        test_reset_mid_mem;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
